// File: rtl/vga_timing_if.sv
// VGA timing bundle: scan position, blanking and sync lines
// from the timing generator to the image source and monitor.
interface vga_timing_if;
  logic [9:0] Column;
  logic [9:0] Row;
  logic       Display;
  logic       hsync_out;
  logic       vsync_out;
  logic       line_start;
  logic       frame_start;

  modport master (
    output Column, Row, Display,
    output hsync_out, vsync_out,
    output line_start, frame_start
  );

  modport slave (
    input Column, Row, Display,
    input hsync_out, vsync_out,
    input line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-clock VGA timing generator: independent H/V phase FSMs,
// registered position/blanking outputs, delayed sync outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic         pxclk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

  h_state_t   h_state, h_state_nx;
  v_state_t   v_state, v_state_nx;
  logic [9:0] h_cnt, h_cnt_nx;
  logic [9:0] v_cnt, v_cnt_nx;
  logic [9:0] hc, vc;
  logic       h_wrap;

  logic [9:0] col_q, row_q;
  logic       disp_q, ls_q, fs_q;
  logic       hs_raw, vs_raw;

  assign h_wrap = (hc == H_LAST);

  // State registers and position counters
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      h_state <= H_ACT;
      v_state <= V_ACT;
      h_cnt   <= 10'(H_ACTIVE - 1);
      v_cnt   <= 10'(V_ACTIVE - 1);
      hc      <= '0;
      vc      <= '0;
    end else begin
      h_state <= h_state_nx;
      v_state <= v_state_nx;
      h_cnt   <= h_cnt_nx;
      v_cnt   <= v_cnt_nx;
      hc      <= h_wrap ? '0 : hc + 10'd1;
      if (h_wrap)
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end
  end

  // Horizontal phase sequencing: next phase when its count expires
  always_comb begin
    h_state_nx = h_state;
    h_cnt_nx   = h_cnt - 10'd1;
    if (h_cnt == '0) begin
      unique case (h_state)
        H_ACT: begin h_state_nx = H_FP;  h_cnt_nx = 10'(H_FRONT - 1);  end
        H_FP:  begin h_state_nx = H_SY;  h_cnt_nx = 10'(H_SYNC - 1);   end
        H_SY:  begin h_state_nx = H_BP;  h_cnt_nx = 10'(H_BACK - 1);   end
        H_BP:  begin h_state_nx = H_ACT; h_cnt_nx = 10'(H_ACTIVE - 1); end
      endcase
    end
  end

  // Vertical phase sequencing: steps only at end of line
  always_comb begin
    v_state_nx = v_state;
    v_cnt_nx   = v_cnt;
    if (h_wrap) begin
      v_cnt_nx = v_cnt - 10'd1;
      if (v_cnt == '0) begin
        unique case (v_state)
          V_ACT: begin v_state_nx = V_FP;  v_cnt_nx = 10'(V_FRONT - 1);  end
          V_FP:  begin v_state_nx = V_SY;  v_cnt_nx = 10'(V_SYNC - 1);   end
          V_SY:  begin v_state_nx = V_BP;  v_cnt_nx = 10'(V_BACK - 1);   end
          V_BP:  begin v_state_nx = V_ACT; v_cnt_nx = 10'(V_ACTIVE - 1); end
        endcase
      end
    end
  end

  // Registered decode of position, blanking, pulses and raw sync
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      disp_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      hs_raw <= ~H_POL;
      vs_raw <= ~V_POL;
    end else begin
      col_q  <= hc;
      row_q  <= vc;
      disp_q <= (h_state == H_ACT) && (v_state == V_ACT);
      ls_q   <= (hc == '0);
      fs_q   <= (hc == '0) && (vc == '0);
      hs_raw <= (h_state == H_SY) ? H_POL : ~H_POL;
      vs_raw <= (v_state == V_SY) ? V_POL : ~V_POL;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign vga.hsync_out = hs_raw;
      assign vga.vsync_out = vs_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hsr, vsr;
      // Sync delay line keeps sync aligned with registered RGB
      always_ff @(posedge pxclk or posedge rst) begin
        if (rst) begin
          hsr <= {SYNC_DELAY{~H_POL}};
          vsr <= {SYNC_DELAY{~V_POL}};
        end else begin
          hsr[0] <= hs_raw;
          vsr[0] <= vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hsr[i] <= hsr[i-1];
            vsr[i] <= vsr[i-1];
          end
        end
      end
      assign vga.hsync_out = hsr[SYNC_DELAY-1];
      assign vga.vsync_out = vsr[SYNC_DELAY-1];
    end
  endgenerate

  assign vga.Column      = col_q;
  assign vga.Row         = row_q;
  assign vga.Display     = disp_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every
// cycle against an arithmetic scan model, with random resets.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int sd;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       disp;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } exp_t;

  logic pxclk = 1'b0;
  logic rst   = 1'b0;
  always #5 pxclk = ~pxclk;

  vga_timing_if ia ();
  vga_timing_if ib ();
  vga_timing_if ic ();

  vga_timing_gen u_a (
    .pxclk (pxclk),
    .rst   (rst),
    .vga   (ia.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .H_POL(1'b1), .V_POL(1'b1), .SYNC_DELAY(3)
  ) u_b (
    .pxclk (pxclk),
    .rst   (rst),
    .vga   (ib.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(0)
  ) u_c (
    .pxclk (pxclk),
    .rst   (rst),
    .vga   (ic.master)
  );

  cfg_t ca = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0};
  cfg_t cb = '{20, 3, 4, 5, 12, 2, 3, 4, 3, 1'b1, 1'b1};
  cfg_t cc = '{4, 1, 2, 1, 3, 1, 1, 1, 0, 1'b0, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;
  longint k  = 0;

  // k = rising edges since reset release; edge k shows scan index k-1
  always @(posedge pxclk or posedge rst)
    if (rst) k = 0;
    else     k = k + 1;

  function automatic exp_t model(cfg_t c, longint kk);
    exp_t e;
    longint ht, vt, p, q, pp, x, y;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e = '{col: '0, row: '0, disp: 1'b0, hs: ~c.hp,
          vs: ~c.vp, ls: 1'b0, fs: 1'b0};
    if (kk >= 1) begin
      p = (kk - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
      e.col  = 10'(x);
      e.row  = 10'(y);
      e.disp = (x < c.ha) && (y < c.va);
      e.ls   = (x == 0);
      e.fs   = (p == 0);
    end
    q = kk - c.sd;
    if (q >= 1) begin
      pp = (q - 1) % (ht * vt);
      x = pp % ht;
      y = pp / ht;
      if (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs)
        e.hs = c.hp;
      if (y >= c.va + c.vf && y < c.va + c.vf + c.vs)
        e.vs = c.vp;
    end
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("col=%0d row=%0d disp=%b hs=%b vs=%b ls=%b fs=%b",
                     e.col, e.row, e.disp, e.hs, e.vs, e.ls, e.fs);
  endfunction

  task automatic check(string nm, exp_t act, exp_t want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s k=%0d got %s want %s",
               nm, k, fmt(act), fmt(want));
    end
  endtask

  task automatic pin(string nm, longint got, longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic exp_t snap_a();
    return '{ia.Column, ia.Row, ia.Display, ia.hsync_out,
             ia.vsync_out, ia.line_start, ia.frame_start};
  endfunction
  function automatic exp_t snap_b();
    return '{ib.Column, ib.Row, ib.Display, ib.hsync_out,
             ib.vsync_out, ib.line_start, ib.frame_start};
  endfunction
  function automatic exp_t snap_c();
    return '{ic.Column, ic.Row, ic.Display, ic.hsync_out,
             ic.vsync_out, ic.line_start, ic.frame_start};
  endfunction

  task automatic check_all(string tag);
    check({tag, "_a"}, snap_a(), model(ca, k));
    check({tag, "_b"}, snap_b(), model(cb, k));
    check({tag, "_c"}, snap_c(), model(cc, k));
  endtask

  // Per-cycle compare, away from the active edge
  always @(negedge pxclk) check_all("cyc");

  task automatic pin_model();
    exp_t e;
    e = model(ca, 1);
    pin("m_start_col", e.col, 0);
    pin("m_start_disp", e.disp, 1);
    pin("m_start_fs", e.fs, 1);
    pin("m_a_hs_657", model(ca, 657).hs, 1);
    pin("m_a_hs_658", model(ca, 658).hs, 0);
    pin("m_a_hs_753", model(ca, 753).hs, 0);
    pin("m_a_hs_754", model(ca, 754).hs, 1);
    pin("m_a_disp_640", model(ca, 641).disp, 0);
    pin("m_a_vs_pre", model(ca, 490 * 800 + 1).vs, 1);
    pin("m_a_vs_on", model(ca, 490 * 800 + 2).vs, 0);
    pin("m_a_vs_last", model(ca, 492 * 800 + 1).vs, 0);
    pin("m_a_vs_off", model(ca, 492 * 800 + 2).vs, 1);
    e = model(ca, 420000);
    pin("m_a_wrap_col", e.col, 799);
    pin("m_a_wrap_row", e.row, 524);
    e = model(ca, 420001);
    pin("m_a_frame_fs", e.fs, 1);
    pin("m_a_frame_row", e.row, 0);
    pin("m_a_r480_disp", model(ca, 480 * 800 + 1).disp, 0);
    pin("m_c_hs_5", model(cc, 5).hs, 1);
    pin("m_c_hs_6", model(cc, 6).hs, 0);
    pin("m_c_fs_49", model(cc, 49).fs, 1);
    pin("m_b_hs_pol", model(cb, 27).hs, 1);
    pin("m_b_hs_idle", model(cb, 26).hs, 0);
  endtask

  task automatic wait_neg(int n);
    repeat (n) @(negedge pxclk);
  endtask

  initial begin
    bit found;
    pin_model();

    #1 rst = 1'b1;
    wait_neg(5);
    pin("rst_hold_hs_a", ia.hsync_out, 1);
    pin("rst_hold_vs_a", ia.vsync_out, 1);
    rst = 1'b0;
    wait_neg(1);
    pin("first_col_a", ia.Column, 0);
    pin("first_disp_a", ia.Display, 1);
    pin("first_fs_a", ia.frame_start, 1);
    wait_neg(3000);

    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      wait_neg(1);
      if (ib.Column == 10'd25 && ib.Row == 10'd14)
        found = 1'b1;
    end
    pin("find_b_vsync", found, 1);
    pin("b_vs_active", ib.vsync_out, 1);
    #2 rst = 1'b1;
    #1;
    check_all("async");
    pin("async_b_vs", ib.vsync_out, 0);
    pin("async_b_col", ib.Column, 0);
    wait_neg(3);
    rst = 1'b0;
    wait_neg(1);
    pin("restart_b_col", ib.Column, 0);
    pin("restart_b_row", ib.Row, 0);
    pin("restart_b_fs", ib.frame_start, 1);
    wait_neg(1500);

    for (int r = 0; r < 4; r++) begin
      wait_neg($urandom_range(50, 900));
      #($urandom_range(1, 3)) rst = 1'b1;
      #1;
      check_all("rnd_rst");
      wait_neg($urandom_range(1, 4));
      rst = 1'b0;
    end
    wait_neg(800);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock timing generator for the VGA output path. Scans a frame and emits `Column`, `Row` and `Display` to the downstream image source, plus `hsync_out`/`vsync_out` for the monitor. The horizontal and vertical timing run as independent phase state machines. The sync outputs have a programmable delay so they stay aligned with the downstream registered RGB stage.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level
- `SYNC_DELAY`, 1, extra cycles added to the sync outputs relative to `Column`/`Row`/`Display`; legal range 0..4

Ports:
- `pxclk`  in  1  pixel clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Column`  out  10  horizontal position, 0..H_TOTAL-1
- `Row`  out  10  vertical position, 0..V_TOTAL-1
- `Display`  out  1  high when both positions are in the active region
- `hsync_out`  out  1  horizontal sync, delayed by SYNC_DELAY
- `vsync_out`  out  1  vertical sync, delayed by SYNC_DELAY
- `line_start`  out  1  one-cycle pulse, aligned with `Column`==0
- `frame_start`  out  1  one-cycle pulse, aligned with `Column`==0 and `Row`==0

## Operation
- Totals: H_TOTAL = sum of the H_* phases = 800; V_TOTAL = sum of the V_* phases = 525. Both totals must be ≤1024 and every phase ≥1.
- Horizontal FSM states: H_ACT → H_FP → H_SY → H_BP → H_ACT.
  - Each phase has its own down-counter, loaded with (phase length − 1).
  - The FSM moves to the next state when that counter reaches 0.
  - The position counter `hc` increments every cycle and wraps to 0 after H_TOTAL−1.
- Vertical FSM states: V_ACT → V_FP → V_SY → V_BP → V_ACT.
  - Advances only on the cycle where `hc` wraps (end of line).
  - The line counter `vc` wraps to 0 after V_TOTAL−1.
  - The vertical state changes exactly at a line boundary, never mid-line.
- Decoded outputs, all registered:
  - `Column` = `hc`, `Row` = `vc`.
  - `Display` = (H state is H_ACT) and (V state is V_ACT).
  - Raw hsync is active when the H state is H_SY; raw vsync is active when the V state is V_SY.
  - `line_start` = (`hc`==0); `frame_start` = (`hc`==0 and `vc`==0).
- Sync delay: raw hsync/vsync pass through a SYNC_DELAY-deep shift register.
  - Each stage resets to the inactive level.
  - SYNC_DELAY=0 bypasses the register.
- Consistency: the FSM state must always agree with the counters. Active region is `hc`<H_ACTIVE; hsync region is H_ACTIVE+H_FRONT ≤ `hc` < H_ACTIVE+H_FRONT+H_SYNC. The same rules apply vertically.

## Timing
- Reset, asynchronous, takes effect immediately:
  - `hc`=0, `vc`=0, both FSMs in the ACT state.
  - Outputs: `Column`=0, `Row`=0, `Display`=0, `line_start`=0, `frame_start`=0.
  - `hsync_out` = ~H_POL, `vsync_out` = ~V_POL; all delay stages at the inactive level.
- First rising edge after `rst` deasserts: outputs show position (0,0), with `Display`=1, `line_start`=1, `frame_start`=1. Position then advances by one per cycle.
- Latency:
  - `Column`/`Row`/`Display`/pulses lag the internal counters by exactly 1 cycle.
  - Sync outputs lag `Column`/`Row` by SYNC_DELAY cycles.
  - With the default of 1, the sync outputs align with a downstream stage that registers RGB one cycle after `Column`/`Row`.
- Defaults:
  - hsync is active for `Column` 656..751 (96 cycles).
  - vsync is active from (`Column` 0, `Row` 490) through (`Column` 799, `Row` 491), i.e. 1600 cycles. The timing is referenced to `Column`/`Row`, before the sync delay is applied.
- Wrap:
  - After (799, `Row` r), the next position is (0, r+1).
  - After (799, 524), the next position is (0, 0), with `line_start` and `frame_start` both pulsing that cycle.
- Frame period: exactly H_TOTAL×V_TOTAL = 420000 cycles between `frame_start` pulses.
- Reset asserted mid-frame: everything returns to the reset values at once; the scan restarts at (0,0) on the first edge after release. No partial sync pulse may be stretched.

## Test plan
- Reset/startup: hold `rst` for 5 cycles → all outputs at the reset values, sync lines high (default polarity). Release → first edge shows `Column`=0, `Row`=0, `Display`=1, `frame_start`=1.
- Line timing (default parameters): hsync low for exactly 96 cycles, starting 656 cycles after `line_start` plus SYNC_DELAY. `Display` high for 640 cycles per visible line. `line_start` period is 800 cycles.
- Frame timing: `Display` is never high for `Row`≥480. vsync low for exactly 1600 cycles, beginning at `Row` 490, `Column` 0 (+SYNC_DELAY). Wrap (799, 524) → (0, 0) with `frame_start`=1. Two consecutive `frame_start` pulses are 420000 cycles apart.
- Delay/polarity: run SYNC_DELAY=0, 1 and 3, and H_POL=1 → hsync edges shift by exactly 0, 1 and 3 cycles relative to `Column`; the active level is inverted when H_POL=1.
- Small configuration (H: 4/1/2/1, V: 3/1/1/1): check the full `Column`/`Row`/`Display`/sync sequence cycle by cycle against a reference model over 3 frames.
- Asynchronous reset mid-sync: assert `rst` at `Row` 490, `Column` 700, between clock edges → outputs return to reset values immediately (vsync high, `Column`=0). After release, the scan restarts at (0,0).
